// File: rtl/bram_pkg.sv
// ============================================================================
//  Module      : bram_pkg
//  Description : Shared constants, clear-FSM state encoding and parameter
//                legality helpers for the byte-enable SDP block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_pkg;

    localparam int c_RDW_OLD = 0;
    localparam int c_RDW_NEW = 1;

    typedef logic [0:0] clr_state_t;
    localparam clr_state_t c_ST_CLEAR = 1'b0;
    localparam clr_state_t c_ST_READY = 1'b1;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic bit params_legal(input int data_width, input int read_latency,
                                        input int depth, input int addr_width);
        return (data_width > 0) && (data_width % 8 == 0) &&
               (read_latency >= 1) && (read_latency <= 3) &&
               (depth >= 1) && (depth <= (1 << addr_width));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_rd_pipe.sv
// ============================================================================
//  Module      : bram_rd_pipe
//  Description : Read-data delay line with valid strobe; the output stage
//                holds its last valid word and all valids flush on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  r_vld [LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [LATENCY];

    // Data only advances alongside a valid, so every stage holds its last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_vld[s] <= 1'b0;
                r_dat[s] <= '0;
            end
        end else begin
            r_vld[0] <= in_valid;
            if (in_valid) r_dat[0] <= in_data;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
            end
        end
    end

    assign out_valid = r_vld[LATENCY-1];
    assign out_data  = r_dat[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/bram_sdp_be.sv
// ============================================================================
//  Module      : bram_sdp_be
//  Description : Simple-dual-port RAM with byte-enable writes, pipelined reads,
//                selectable read-during-write policy and post-reset clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_sdp_be
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_busy
);

    localparam int                    c_BE_W     = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST     = ADDR_WIDTH'(DEPTH - 1);
    localparam clr_state_t            c_ST_RESET = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_READY;

    if (!params_legal(DATA_WIDTH, READ_LATENCY, DEPTH, ADDR_WIDTH)) begin : g_bad_params
        $error("bram_sdp_be: illegal DATA_WIDTH/READ_LATENCY/DEPTH/ADDR_WIDTH combination");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_busy;
    logic                  w_clr_we;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_RESET;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr_we) r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_ST_CLEAR && r_clr_cnt == c_LAST) w_state_nxt = c_ST_READY;
    end

    always_comb begin
        w_busy   = (r_state == c_ST_CLEAR);
        w_clr_we = w_busy;
    end

    assign init_busy     = w_busy;
    assign w_wr_ok       = we && !w_busy && ({1'b0, wr_addr} < c_DEPTH);
    assign w_rd_ok       = rd_en && !w_busy;
    assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);

    // The array itself is never reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_ok) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (wr_be[b]) r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read word is captured at the request edge, so later writes never leak in.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr];
            if (RDW_MODE == c_RDW_NEW && w_wr_ok && wr_addr == rd_addr) begin
                for (int b = 0; b < c_BE_W; b++) begin
                    if (wr_be[b]) w_rd_word[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    bram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_rd_ok),
        .in_data   (w_rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_bram_sdp_be.sv
// ============================================================================
//  Module      : tb_bram_sdp_be
//  Description : Self-checking bench driving three RAM configurations with a
//                shared stimulus stream and per-instance expectation queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_sdp_be;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic        vld  [3];
    logic [31:0] rdat [3];
    logic        busy [3];

    int          cyc = 0;
    logic        rst_q = 1'b0;
    int          checks = 0;
    int          errors = 0;
    sb_t         sbq [3][$];
    logic [31:0] held [3];
    int          c_lat [3] = '{2, 3, 1};
    int          c_dep [3] = '{16, 16, 12};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    bram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2),
                  .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdat[0]), .rd_valid(vld[0]), .init_busy(busy[0]));

    bram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(3),
                  .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdat[1]), .rd_valid(vld[1]), .init_busy(busy[1]));

    bram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(1),
                  .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdat[2]), .rd_valid(vld[2]), .init_busy(busy[2]));

    task automatic note(input int i, input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on rd_valid, checks hold otherwise.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_q) held[i] = '0;
            if (vld[i] === 1'b1) begin
                if (sbq[i].size() == 0 || sbq[i][0].due != cyc) begin
                    note(i, 1'b0, "unexpected_rd_valid", 32'd1, 32'd0);
                end else begin
                    note(i, rdat[i] === sbq[i][0].data, "rd_data", rdat[i], sbq[i][0].data);
                    held[i] = sbq[i][0].data;
                    void'(sbq[i].pop_front());
                end
            end else begin
                if (sbq[i].size() != 0 && sbq[i][0].due <= cyc) begin
                    note(i, 1'b0, "missing_rd_valid", 32'd0, 32'd1);
                    void'(sbq[i].pop_front());
                end
                note(i, rdat[i] === held[i], "rd_data_hold", rdat[i], held[i]);
            end
        end
    end

    function automatic vec_t mkv(logic w, logic [3:0] wa, logic [3:0] be, logic [31:0] wd,
                                 logic r, logic [3:0] ra,
                                 logic [31:0] ea, logic [31:0] eb, logic [31:0] ec);
        vec_t v;
        v.we = w;  v.wa = wa; v.be = be; v.wd = wd;
        v.re = r;  v.ra = ra; v.ea = ea; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic step(input vec_t v);
        @(negedge clk);
        we = v.we; wr_addr = v.wa; wr_be = v.be; wr_data = v.wd;
        rd_en = v.re; rd_addr = v.ra;
        if (v.re) begin
            sbq[0].push_back('{data: v.ea, due: cyc + c_lat[0]});
            sbq[1].push_back('{data: v.eb, due: cyc + c_lat[1]});
            sbq[2].push_back('{data: v.ec, due: cyc + c_lat[2]});
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] ea,
                      input logic [31:0] eb, input logic [31:0] ec);
        step(mkv(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, a, ea, eb, ec));
    endtask

    // Releases reset and measures how many samples each instance stays busy.
    task automatic measure_sweep();
        int  first [3];
        bit  done;
        for (int i = 0; i < 3; i++) first[i] = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 0) begin
                for (int i = 0; i < 3; i++) begin
                    note(i, vld[i] === 1'b0, "reset_rd_valid", 32'(vld[i]), 32'd0);
                    note(i, rdat[i] === 32'd0, "reset_rd_data", rdat[i], 32'd0);
                end
            end
            done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (first[i] < 0 && busy[i] === 1'b0) first[i] = k;
                if (first[i] < 0) done = 1'b0;
            end
            if (done) break;
            rst_n   = 1'b1;
            rd_en   = (k >= 1 && k <= 8);
            rd_addr = 4'(k);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++)
            note(i, first[i] == c_dep[i], "sweep_length", 32'(first[i]), 32'(c_dep[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [20];
        logic [31:0] img_ab [16];
        logic [31:0] img_c  [16];
        vec_t        idle;

        for (int i = 0; i < 3; i++) held[i] = '0;
        idle = mkv(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);

        tbl[0]  = mkv(1, 4'd5,  4'hF, 32'hAABBCCDD, 0, 4'd0,  32'h0, 32'h0, 32'h0);
        tbl[1]  = mkv(1, 4'd5,  4'h5, 32'h11223344, 0, 4'd0,  32'h0, 32'h0, 32'h0);
        tbl[2]  = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd5,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
        tbl[3]  = mkv(1, 4'd3,  4'h3, 32'hFFFFFFFF, 1, 4'd3,  32'h0, 32'h0000FFFF, 32'h0);
        tbl[4]  = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd3,  32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
        tbl[5]  = mkv(1, 4'd13, 4'hF, 32'h5A5A5A5A, 1, 4'd13, 32'h0, 32'h5A5A5A5A, 32'h0);
        tbl[6]  = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd13, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0);
        tbl[7]  = mkv(1, 4'd7,  4'h8, 32'hDEADBEEF, 1, 4'd5,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
        tbl[8]  = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd7,  32'hDE000000, 32'hDE000000, 32'hDE000000);
        tbl[9]  = mkv(1, 4'd7,  4'h0, 32'hFFFFFFFF, 1, 4'd7,  32'hDE000000, 32'hDE000000, 32'hDE000000);
        tbl[10] = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd7,  32'hDE000000, 32'hDE000000, 32'hDE000000);
        tbl[11] = mkv(0, 4'd7,  4'hF, 32'h00000001, 0, 4'd0,  32'h0, 32'h0, 32'h0);
        tbl[12] = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd7,  32'hDE000000, 32'hDE000000, 32'hDE000000);
        tbl[13] = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd11, 32'h0, 32'h0, 32'h0);
        tbl[14] = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd0,  32'h0, 32'h0, 32'h0);
        tbl[15] = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd2,  32'h0, 32'h0, 32'h0);
        tbl[16] = mkv(1, 4'd2,  4'hF, 32'h12345678, 0, 4'd0,  32'h0, 32'h0, 32'h0);
        tbl[17] = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd2,  32'h12345678, 32'h12345678, 32'h12345678);
        tbl[18] = mkv(1, 4'd12, 4'hF, 32'h77777777, 1, 4'd12, 32'h0, 32'h77777777, 32'h0);
        tbl[19] = mkv(0, 4'd0,  4'h0, 32'h0,        1, 4'd12, 32'h77777777, 32'h77777777, 32'h0);

        for (int a = 0; a < 16; a++) begin
            img_ab[a] = 32'h0;
            img_c[a]  = 32'h0;
        end
        img_ab[2]  = 32'h12345678; img_ab[3] = 32'h0000FFFF;
        img_ab[5]  = 32'hAA22CC44; img_ab[7] = 32'hDE000000;
        img_ab[12] = 32'h77777777; img_ab[13] = 32'h5A5A5A5A;
        for (int a = 0; a < 12; a++) img_c[a] = img_ab[a];

        // Reset held for a few cycles, then reset values.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            note(i, vld[i] === 1'b0, "rst_rd_valid", 32'(vld[i]), 32'd0);
            note(i, rdat[i] === 32'd0, "rst_rd_data", rdat[i], 32'd0);
            note(i, busy[i] === 1'b1, "rst_init_busy", 32'(busy[i]), 32'd1);
        end

        measure_sweep();

        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, 32'h0, 32'h0);

        for (int n = 0; n < 20; n++) step(tbl[n]);

        for (int a = 0; a < 16; a++) rd(4'(a), img_ab[a], img_ab[a], img_c[a]);

        // Streaming: preload value = addr, then back-to-back reads.
        for (int a = 0; a < 8; a++)
            step(mkv(1'b1, 4'(a), 4'hF, 32'(a), 1'b0, 4'd0, 32'h0, 32'h0, 32'h0));
        for (int a = 0; a < 8; a++) rd(4'(a), 32'(a), 32'(a), 32'(a));
        repeat (4) step(idle);

        // Reset with reads in flight: entries that would surface after the
        // reset edge are discarded.
        rd(4'd1, 32'd1, 32'd1, 32'd1);
        rd(4'd2, 32'd2, 32'd2, 32'd2);
        @(negedge clk);
        rst_n = 1'b0; we = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 3; i++)
            while (sbq[i].size() > 0 && sbq[i][$].due > cyc) void'(sbq[i].pop_back());

        measure_sweep();

        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, 32'h0, 32'h0);

        repeat (6) step(idle);
        for (int i = 0; i < 3; i++)
            note(i, sbq[i].size() == 0, "scoreboard_empty", 32'(sbq[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
